// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file and its read ports.
package regfile_pkg;

    localparam int RegWidth     = 32;
    localparam int RegNum       = 32;
    localparam int RegNumLog2   = 5;

    typedef logic [RegWidth-1:0]   reg_bus_t;
    typedef logic [RegNumLog2-1:0] reg_addr_t;

    localparam reg_bus_t  ZeroWord    = '0;
    localparam reg_addr_t NOPRegAddr  = '0;
    localparam logic      RstEnable   = 1'b1;
    localparam logic      WriteEnable = 1'b1;
    localparam logic      ReadEnable  = 1'b1;

endpackage

// File: rtl/regfile_if.sv
// Writeback, read-port and forwarding bus between the pipeline and the register file.
interface regfile_if;
    import regfile_pkg::*;

    logic      we;
    reg_addr_t waddr;
    reg_bus_t  wdata;
    logic      re1;
    logic      re2;
    reg_addr_t raddr1;
    reg_addr_t raddr2;
    logic      ex_wreg_i;
    reg_addr_t ex_wd_i;
    reg_bus_t  ex_wdata_i;
    logic      ex_load_i;
    logic      mem_wreg_i;
    reg_addr_t mem_wd_i;
    reg_bus_t  mem_wdata_i;
    reg_bus_t  rdata1;
    reg_bus_t  rdata2;
    logic      stallreq;

    modport master (
        output we, waddr, wdata, re1, re2, raddr1, raddr2,
        output ex_wreg_i, ex_wd_i, ex_wdata_i, ex_load_i,
        output mem_wreg_i, mem_wd_i, mem_wdata_i,
        input  rdata1, rdata2, stallreq
    );

    modport slave (
        input  we, waddr, wdata, re1, re2, raddr1, raddr2,
        input  ex_wreg_i, ex_wd_i, ex_wdata_i, ex_load_i,
        input  mem_wreg_i, mem_wd_i, mem_wdata_i,
        output rdata1, rdata2, stallreq
    );

endinterface

// File: rtl/regfile_rdport.sv
// One read port: youngest-producer-first forwarding mux plus load-use match detect.
module regfile_rdport
    import regfile_pkg::*;
(
    input  logic      rst_i,
    input  logic      re_i,
    input  reg_addr_t raddr_i,
    input  logic      ex_wreg_i,
    input  reg_addr_t ex_wd_i,
    input  reg_bus_t  ex_wdata_i,
    input  logic      ex_load_i,
    input  logic      mem_wreg_i,
    input  reg_addr_t mem_wd_i,
    input  reg_bus_t  mem_wdata_i,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  reg_bus_t  wdata_i,
    input  reg_bus_t  arr_rdata_i,
    output reg_bus_t  rdata_o,
    output logic      hazard_o
);

    // x0 check sits ahead of forwarding so a producer targeting x0 never leaks through.
    always_comb begin
        rdata_o = ZeroWord;
        if (rst_i == RstEnable) begin
            rdata_o = ZeroWord;
        end else if (re_i != ReadEnable) begin
            rdata_o = ZeroWord;
        end else if (raddr_i == NOPRegAddr) begin
            rdata_o = ZeroWord;
        end else if (ex_wreg_i == WriteEnable && ex_wd_i == raddr_i) begin
            rdata_o = ex_wdata_i;
        end else if (mem_wreg_i == WriteEnable && mem_wd_i == raddr_i) begin
            rdata_o = mem_wdata_i;
        end else if (we_i == WriteEnable && waddr_i == raddr_i) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = arr_rdata_i;
        end
    end

    always_comb begin
        hazard_o = ex_load_i && (ex_wreg_i == WriteEnable) && (ex_wd_i != NOPRegAddr)
                   && (re_i == ReadEnable) && (raddr_i == ex_wd_i);
    end

endmodule

// File: rtl/regfile.sv
// RISC-V integer register file x0..x31 with two forwarding read ports and load-use stall request.
module regfile
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = RegNum
) (
    input  logic       clk,
    input  logic       rst,
    regfile_if.slave   bus
);

    reg_bus_t regs_q [1:NUM_REGS-1];
    reg_bus_t arr_rd1;
    reg_bus_t arr_rd2;
    logic     hazard1;
    logic     hazard2;

    // Reset clears every entry in one cycle and wins over any concurrent write.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= ZeroWord;
            end
        end else if (bus.we == WriteEnable && bus.waddr != NOPRegAddr) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

    always_comb begin
        arr_rd1 = ZeroWord;
        if (bus.raddr1 != NOPRegAddr) begin
            arr_rd1 = regs_q[bus.raddr1];
        end
    end

    always_comb begin
        arr_rd2 = ZeroWord;
        if (bus.raddr2 != NOPRegAddr) begin
            arr_rd2 = regs_q[bus.raddr2];
        end
    end

    regfile_rdport u_rdport1 (
        .rst_i       (rst),
        .re_i        (bus.re1),
        .raddr_i     (bus.raddr1),
        .ex_wreg_i   (bus.ex_wreg_i),
        .ex_wd_i     (bus.ex_wd_i),
        .ex_wdata_i  (bus.ex_wdata_i),
        .ex_load_i   (bus.ex_load_i),
        .mem_wreg_i  (bus.mem_wreg_i),
        .mem_wd_i    (bus.mem_wd_i),
        .mem_wdata_i (bus.mem_wdata_i),
        .we_i        (bus.we),
        .waddr_i     (bus.waddr),
        .wdata_i     (bus.wdata),
        .arr_rdata_i (arr_rd1),
        .rdata_o     (bus.rdata1),
        .hazard_o    (hazard1)
    );

    regfile_rdport u_rdport2 (
        .rst_i       (rst),
        .re_i        (bus.re2),
        .raddr_i     (bus.raddr2),
        .ex_wreg_i   (bus.ex_wreg_i),
        .ex_wd_i     (bus.ex_wd_i),
        .ex_wdata_i  (bus.ex_wdata_i),
        .ex_load_i   (bus.ex_load_i),
        .mem_wreg_i  (bus.mem_wreg_i),
        .mem_wd_i    (bus.mem_wd_i),
        .mem_wdata_i (bus.mem_wdata_i),
        .we_i        (bus.we),
        .waddr_i     (bus.waddr),
        .wdata_i     (bus.wdata),
        .arr_rdata_i (arr_rd2),
        .rdata_o     (bus.rdata2),
        .hazard_o    (hazard2)
    );

    always_comb begin
        bus.stallreq = (rst != RstEnable) && (hazard1 || hazard2);
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed test-plan cases plus randomized traffic against a reference model.
module tb_regfile;

    logic clk = 1'b0;
    logic rst = 1'b0;

    regfile_if rf_if ();

    regfile #(.NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] mdl [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rf_if.we = 0; rf_if.waddr = 0; rf_if.wdata = 0;
        rf_if.re1 = 0; rf_if.re2 = 0; rf_if.raddr1 = 0; rf_if.raddr2 = 0;
        rf_if.ex_wreg_i = 0; rf_if.ex_wd_i = 0; rf_if.ex_wdata_i = 0; rf_if.ex_load_i = 0;
        rf_if.mem_wreg_i = 0; rf_if.mem_wd_i = 0; rf_if.mem_wdata_i = 0;
    endtask

    // Clock edge: model commits what the DUT should commit, then settle 1 time unit.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
        end else if (rf_if.we && rf_if.waddr != 0) begin
            mdl[rf_if.waddr] = rf_if.wdata;
        end
        #1;
    endtask

    function automatic logic [31:0] ref_read(input logic re, input logic [4:0] a);
        if (rst || !re || a == 0) return 32'h0;
        if (rf_if.ex_wreg_i && rf_if.ex_wd_i == a) return rf_if.ex_wdata_i;
        if (rf_if.mem_wreg_i && rf_if.mem_wd_i == a) return rf_if.mem_wdata_i;
        if (rf_if.we && rf_if.waddr == a) return rf_if.wdata;
        return mdl[a];
    endfunction

    function automatic logic ref_match(input logic re, input logic [4:0] a);
        return re && a == rf_if.ex_wd_i;
    endfunction

    task automatic check_model(input string tag);
        logic stall_load;
        logic m1, m2;
        #1;
        stall_load = !rst && rf_if.ex_load_i && rf_if.ex_wreg_i && rf_if.ex_wd_i != 0;
        m1 = stall_load && ref_match(rf_if.re1, rf_if.raddr1);
        m2 = stall_load && ref_match(rf_if.re2, rf_if.raddr2);
        chk({tag, ".stall"}, {31'b0, rf_if.stallreq}, {31'b0, m1 || m2});
        if (!m1) chk({tag, ".rd1"}, rf_if.rdata1, ref_read(rf_if.re1, rf_if.raddr1));
        if (!m2) chk({tag, ".rd2"}, rf_if.rdata2, ref_read(rf_if.re2, rf_if.raddr2));
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        rf_if.we = 1; rf_if.waddr = a; rf_if.wdata = d;
        tick();
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        idle();
        rst = 1;
        tick();
        rst = 0;

        // Reset clear
        wr(5'd5, 32'hDEADBEEF);
        rf_if.re1 = 1; rf_if.raddr1 = 5; #1;
        chk("preload_x5", rf_if.rdata1, 32'hDEADBEEF);
        rst = 1;
        rf_if.we = 1; rf_if.waddr = 6; rf_if.wdata = 32'h6666_6666;
        rf_if.ex_wreg_i = 1; rf_if.ex_wd_i = 5; rf_if.ex_wdata_i = 32'h1111_1111;
        rf_if.ex_load_i = 1; rf_if.re2 = 1; rf_if.raddr2 = 5;
        #1;
        chk("rst_rd1", rf_if.rdata1, 32'h0);
        chk("rst_rd2", rf_if.rdata2, 32'h0);
        chk("rst_stall", {31'b0, rf_if.stallreq}, 32'h0);
        tick();
        rst = 0;
        idle();
        rf_if.re1 = 1; rf_if.raddr1 = 5; rf_if.re2 = 1; rf_if.raddr2 = 6; #1;
        chk("after_rst_x5", rf_if.rdata1, 32'h0);
        chk("after_rst_x6_dropped", rf_if.rdata2, 32'h0);
        chk("after_rst_stall", {31'b0, rf_if.stallreq}, 32'h0);

        // Write and x0
        wr(5'd7, 32'h1234_5678);
        rf_if.re1 = 1; rf_if.raddr1 = 7; rf_if.re2 = 1; rf_if.raddr2 = 7; #1;
        chk("x7_p1", rf_if.rdata1, 32'h1234_5678);
        chk("x7_p2", rf_if.rdata2, 32'h1234_5678);
        wr(5'd0, 32'hFFFF_FFFF);
        rf_if.re1 = 1; rf_if.raddr1 = 0; #1;
        chk("x0_write_ignored", rf_if.rdata1, 32'h0);

        // Bypass priority
        wr(5'd3, 32'h1);
        rf_if.re1 = 1; rf_if.raddr1 = 3; rf_if.re2 = 1; rf_if.raddr2 = 3;
        rf_if.we = 1; rf_if.waddr = 3; rf_if.wdata = 32'h2;
        rf_if.mem_wreg_i = 1; rf_if.mem_wd_i = 3; rf_if.mem_wdata_i = 32'h3;
        rf_if.ex_wreg_i = 1; rf_if.ex_wd_i = 3; rf_if.ex_wdata_i = 32'h4;
        #1; chk("byp_ex", rf_if.rdata1, 32'h4); chk("byp_ex_p2", rf_if.rdata2, 32'h4);
        rf_if.ex_wreg_i = 0;
        #1; chk("byp_mem", rf_if.rdata1, 32'h3);
        rf_if.mem_wreg_i = 0;
        #1; chk("byp_wb", rf_if.rdata1, 32'h2);
        rf_if.we = 0;
        #1; chk("byp_arr", rf_if.rdata1, 32'h1);
        idle();

        // x0 forwarding
        rf_if.ex_wreg_i = 1; rf_if.ex_wd_i = 0; rf_if.ex_wdata_i = 32'hAAAA_AAAA;
        rf_if.re1 = 1; rf_if.raddr1 = 0; #1;
        chk("x0_fwd", rf_if.rdata1, 32'h0);
        idle();

        // Load-use
        rf_if.ex_load_i = 1; rf_if.ex_wreg_i = 1; rf_if.ex_wd_i = 9;
        rf_if.re2 = 1; rf_if.raddr2 = 9; #1;
        chk("lu_stall", {31'b0, rf_if.stallreq}, 32'h1);
        rf_if.re2 = 0; #1;
        chk("lu_re_off", {31'b0, rf_if.stallreq}, 32'h0);
        rf_if.re2 = 1; rf_if.ex_wd_i = 0; rf_if.raddr2 = 0; #1;
        chk("lu_x0", {31'b0, rf_if.stallreq}, 32'h0);
        idle();

        // Read disable
        wr(5'd4, 32'h55);
        rf_if.re1 = 0; rf_if.raddr1 = 4; rf_if.re2 = 1; rf_if.raddr2 = 4; #1;
        chk("re1_off", rf_if.rdata1, 32'h0);
        chk("re2_on", rf_if.rdata2, 32'h55);
        idle();

        // Randomized traffic on a narrow address window to provoke collisions
        for (int n = 0; n < 400; n++) begin
            rst              = ($urandom_range(0, 31) == 0);
            rf_if.we         = $urandom_range(0, 1);
            rf_if.waddr      = 5'($urandom_range(0, 7));
            rf_if.wdata      = $urandom;
            rf_if.re1        = ($urandom_range(0, 3) != 0);
            rf_if.re2        = ($urandom_range(0, 3) != 0);
            rf_if.raddr1     = 5'($urandom_range(0, 7));
            rf_if.raddr2     = 5'($urandom_range(0, 7));
            rf_if.ex_wreg_i  = $urandom_range(0, 1);
            rf_if.ex_wd_i    = 5'($urandom_range(0, 7));
            rf_if.ex_wdata_i = $urandom;
            rf_if.ex_load_i  = ($urandom_range(0, 2) == 0);
            rf_if.mem_wreg_i = $urandom_range(0, 1);
            rf_if.mem_wd_i   = 5'($urandom_range(0, 7));
            rf_if.mem_wdata_i = $urandom;
            check_model("rand");
            tick();
        end
        rst = 0;
        idle();

        // Final sweep of the array through both ports
        for (int a = 0; a < 32; a++) begin
            rf_if.re1 = 1; rf_if.raddr1 = 5'(a);
            rf_if.re2 = 1; rf_if.raddr2 = 5'(31 - a);
            check_model("sweep");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
